// File: rtl/exu_branch_resolve_unit.sv
// Branch resolution stage: resolves JAL/JALR/B-type direction and target against the
// fetch prediction, keeps a return address stack and a saturating misprediction counter.
module exu_branch_resolve_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  PC_INIT   = '0,
    parameter int               RAS_DEPTH = 4,
    parameter int               BPCW      = 8,
    parameter int               CNTW      = 16
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                i_stall,
    input  logic                i_bubble,
    input  logic [XLEN-1:0]     i_pc,
    input  logic                i_is_jal,
    input  logic                i_is_jalr,
    input  logic                i_is_b_type,
    input  logic [4:0]          i_rd,
    input  logic [4:0]          i_rs1,
    input  logic [2:0]          i_funct3,
    input  logic [11:0]         i_immI,
    input  logic [11:0]         i_immB,
    input  logic [XLEN-1:0]     i_op0,
    input  logic [XLEN-1:0]     i_op1,
    input  logic                i_op0_lt_op1,
    input  logic                i_sign_op0_lt_op1,
    input  logic                i_pred_taken,
    input  logic [XLEN-1:0]     i_pred_pc,
    input  logic                i_cnt_clr,
    output logic [XLEN-1:0]     o_nxt_instr_pc,
    output logic                o_bubble,
    output logic                o_branch_taken,
    output logic [XLEN-1:0]     o_branch_pc,
    output logic                o_flush,
    output logic [XLEN-1:0]     o_ras_top,
    output logic                o_ras_valid,
    output logic                o_bp_upd,
    output logic [BPCW-1:0]     o_bp_idx_pc,
    output logic                o_bp_sts_btaken,
    output logic [CNTW-1:0]     o_mispred_cnt
);

    localparam int TPW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [TPW-1:0]  r_tp;
    logic [TPW:0]    r_cnt;

    logic            r_en_cmp;
    logic            r_dir_mis;
    logic            r_tgt_mis;
    logic [CNTW-1:0] r_mispred_cnt;

    logic [XLEN-1:0] r_nxt_instr_pc;
    logic            r_bubble;
    logic            r_branch_taken;
    logic [XLEN-1:0] r_branch_pc;
    logic            r_bp_upd;
    logic [BPCW-1:0] r_bp_idx_pc;
    logic            r_bp_sts_btaken;

    logic            w_flush;
    logic            w_accept;
    logic            w_jump;
    logic            w_b_cond;
    logic            w_b_legal;
    logic            w_taken;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_jalr_sum;
    logic [XLEN-1:0] w_b_tgt;
    logic [XLEN-1:0] w_branch_pc;
    logic            w_dir_mis;
    logic            w_tgt_mis;
    logic            w_rd_link;
    logic            w_rs1_link;
    logic            w_link_swap;
    logic            w_push;
    logic            w_pop;
    logic            w_pop_push;
    logic [TPW-1:0]  w_tp_inc;
    logic [TPW-1:0]  w_tp_dec;

    // A flushing cycle's instruction is on the wrong path and is treated as a bubble.
    assign w_flush  = r_en_cmp & (r_dir_mis | r_tgt_mis);
    assign w_accept = !i_stall && !i_bubble && !w_flush;
    assign w_jump   = i_is_jal | i_is_jalr;

    always_comb begin
        w_b_cond  = 1'b0;
        w_b_legal = 1'b1;
        case (i_funct3)
            3'b000:  w_b_cond = (i_op0 == i_op1);
            3'b001:  w_b_cond = (i_op0 != i_op1);
            3'b100:  w_b_cond = i_sign_op0_lt_op1;
            3'b101:  w_b_cond = !i_sign_op0_lt_op1;
            3'b110:  w_b_cond = i_op0_lt_op1;
            3'b111:  w_b_cond = !i_op0_lt_op1;
            default: w_b_legal = 1'b0;
        endcase
    end

    assign w_taken    = w_jump | (i_is_b_type & w_b_cond);
    assign w_pc4      = i_pc + XLEN'(4);
    assign w_jalr_sum = i_op0 + {{(XLEN-12){i_immI[11]}}, i_immI};
    assign w_b_tgt    = i_pc + {{(XLEN-13){i_immB[11]}}, i_immB, 1'b0};

    // JAL targets are trusted from fetch, so a JAL can only mispredict on direction.
    always_comb begin
        if (i_is_jal)
            w_branch_pc = i_pred_pc;
        else if (i_is_jalr)
            w_branch_pc = {w_jalr_sum[XLEN-1:1], 1'b0};
        else if (i_is_b_type && w_b_cond)
            w_branch_pc = w_b_tgt;
        else
            w_branch_pc = w_pc4;
    end

    assign w_dir_mis = (w_taken != i_pred_taken);
    assign w_tgt_mis = w_taken && (w_branch_pc != i_pred_pc);

    assign w_rd_link   = (i_rd == 5'd1) || (i_rd == 5'd5);
    assign w_rs1_link  = (i_rs1 == 5'd1) || (i_rs1 == 5'd5);
    assign w_link_swap = i_is_jalr & w_rd_link & w_rs1_link & (i_rd != i_rs1);
    assign w_push      = w_accept & w_jump & w_rd_link & !w_link_swap;
    assign w_pop       = w_accept & i_is_jalr & w_rs1_link & !w_rd_link;
    assign w_pop_push  = w_accept & w_link_swap;
    assign w_tp_inc    = r_tp + TPW'(1);
    assign w_tp_dec    = r_tp - TPW'(1);

    // Circular RAS: overflow silently overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_tp  <= '0;
            r_cnt <= '0;
            for (int k = 0; k < RAS_DEPTH; k++)
                r_ras[k] <= '0;
        end else if (w_push) begin
            r_tp           <= w_tp_inc;
            r_ras[w_tp_inc] <= w_pc4;
            if (r_cnt != (TPW+1)'(RAS_DEPTH))
                r_cnt <= r_cnt + 1'b1;
        end else if (w_pop) begin
            if (r_cnt != '0) begin
                r_tp  <= w_tp_dec;
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (w_pop_push) begin
            r_ras[r_tp] <= w_pc4;
            if (r_cnt == '0)
                r_cnt <= (TPW+1)'(1);
        end
    end

    // Under stall everything holds, except that a live flush is retired and the
    // predictor strobe is dropped so a held instruction cannot update twice.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_nxt_instr_pc  <= PC_INIT;
            r_bubble        <= 1'b1;
            r_branch_taken  <= 1'b0;
            r_branch_pc     <= PC_INIT;
            r_bp_upd        <= 1'b0;
            r_bp_idx_pc     <= '0;
            r_bp_sts_btaken <= 1'b0;
            r_en_cmp        <= 1'b0;
            r_dir_mis       <= 1'b0;
            r_tgt_mis       <= 1'b0;
        end else if (!i_stall) begin
            r_nxt_instr_pc  <= w_pc4;
            r_bubble        <= !(w_accept && w_jump);
            r_branch_taken  <= w_accept && w_taken;
            r_branch_pc     <= w_branch_pc;
            r_bp_upd        <= w_accept && i_is_b_type && w_b_legal;
            r_bp_idx_pc     <= i_pc[BPCW-1:0];
            r_bp_sts_btaken <= w_taken;
            r_en_cmp        <= w_accept;
            r_dir_mis       <= w_dir_mis;
            r_tgt_mis       <= w_tgt_mis;
        end else begin
            r_bp_upd <= 1'b0;
            if (w_flush)
                r_en_cmp <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn)
            r_mispred_cnt <= '0;
        else if (i_cnt_clr)
            r_mispred_cnt <= '0;
        else if (w_flush && (r_mispred_cnt != {CNTW{1'b1}}))
            r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end

    assign o_nxt_instr_pc  = r_nxt_instr_pc;
    assign o_bubble        = r_bubble;
    assign o_branch_taken  = r_branch_taken;
    assign o_branch_pc     = r_branch_pc;
    assign o_flush         = w_flush;
    assign o_ras_top       = r_ras[r_tp];
    assign o_ras_valid     = (r_cnt != '0);
    assign o_bp_upd        = r_bp_upd;
    assign o_bp_idx_pc     = r_bp_idx_pc;
    assign o_bp_sts_btaken = r_bp_sts_btaken;
    assign o_mispred_cnt   = r_mispred_cnt;

endmodule

// File: tb/tb_exu_branch_resolve_unit.sv
// Directed bench for exu_branch_resolve_unit: a cycle model built from the resolution
// rules (queue-based RAS) is compared every cycle, plus literal expectations per scenario.
module tb_exu_branch_resolve_unit;

    localparam int          XLEN = 32;
    localparam int          BPCW = 8;
    localparam int          CNTW = 2;
    localparam int          RASD = 4;
    localparam logic [31:0] PCI  = 32'h0000_0080;
    localparam int          CMAX = (1 << CNTW) - 1;

    logic            clk;
    logic            aresetn;
    logic            i_stall, i_bubble, i_is_jal, i_is_jalr, i_is_b_type;
    logic [31:0]     i_pc, i_op0, i_op1, i_pred_pc;
    logic [4:0]      i_rd, i_rs1;
    logic [2:0]      i_funct3;
    logic [11:0]     i_immI, i_immB;
    logic            i_op0_lt_op1, i_sign_op0_lt_op1, i_pred_taken, i_cnt_clr;
    logic [31:0]     o_nxt_instr_pc, o_branch_pc, o_ras_top;
    logic            o_bubble, o_branch_taken, o_flush, o_ras_valid, o_bp_upd, o_bp_sts_btaken;
    logic [BPCW-1:0] o_bp_idx_pc;
    logic [CNTW-1:0] o_mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    exu_branch_resolve_unit #(
        .XLEN(XLEN), .PC_INIT(PCI), .RAS_DEPTH(RASD), .BPCW(BPCW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .i_stall(i_stall), .i_bubble(i_bubble),
        .i_pc(i_pc), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr), .i_is_b_type(i_is_b_type),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_funct3(i_funct3), .i_immI(i_immI), .i_immB(i_immB),
        .i_op0(i_op0), .i_op1(i_op1), .i_op0_lt_op1(i_op0_lt_op1),
        .i_sign_op0_lt_op1(i_sign_op0_lt_op1), .i_pred_taken(i_pred_taken),
        .i_pred_pc(i_pred_pc), .i_cnt_clr(i_cnt_clr),
        .o_nxt_instr_pc(o_nxt_instr_pc), .o_bubble(o_bubble), .o_branch_taken(o_branch_taken),
        .o_branch_pc(o_branch_pc), .o_flush(o_flush), .o_ras_top(o_ras_top),
        .o_ras_valid(o_ras_valid), .o_bp_upd(o_bp_upd), .o_bp_idx_pc(o_bp_idx_pc),
        .o_bp_sts_btaken(o_bp_sts_btaken), .o_mispred_cnt(o_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_flush = 1'b0, m_bubble = 1'b1, m_taken = 1'b0, m_bp_upd = 1'b0;
    logic        m_mean = 1'b0, m_bt = 1'b0;
    logic [31:0] m_bpc = '0, m_nxt = '0;
    logic [7:0]  m_idx = '0;
    int          m_cnt = 0;
    logic [31:0] m_ras [$];

    always @(posedge clk) begin : model
        logic        acc, tk, legal, mis, rdl, rsl;
        logic [31:0] tgt, pc4;
        if (!aresetn) begin
            m_flush <= 1'b0; m_bubble <= 1'b1; m_taken <= 1'b0; m_bp_upd <= 1'b0;
            m_mean <= 1'b0; m_cnt <= 0;
            m_ras.delete();
        end else begin
            acc   = !i_stall && !i_bubble && !m_flush;
            pc4   = i_pc + 32'd4;
            legal = 1'b1;
            tk    = 1'b0;
            if (i_is_jal || i_is_jalr) tk = 1'b1;
            else if (i_is_b_type) begin
                case (i_funct3)
                    3'd0: tk = (i_op0 == i_op1);
                    3'd1: tk = (i_op0 != i_op1);
                    3'd4: tk = ($signed(i_op0) <  $signed(i_op1));
                    3'd5: tk = ($signed(i_op0) >= $signed(i_op1));
                    3'd6: tk = (i_op0 <  i_op1);
                    3'd7: tk = (i_op0 >= i_op1);
                    default: legal = 1'b0;
                endcase
            end
            if (i_is_jal)       tgt = i_pred_pc;
            else if (i_is_jalr) tgt = (i_op0 + 32'($signed(i_immI))) & ~32'd1;
            else if (tk)        tgt = i_pc + 32'($signed(i_immB)) * 2;
            else                tgt = pc4;
            mis = (tk != i_pred_taken) || (tk && tgt != i_pred_pc);

            if (i_cnt_clr) m_cnt <= 0;
            else if (m_flush && m_cnt < CMAX) m_cnt <= m_cnt + 1;

            if (i_stall) begin
                m_flush  <= 1'b0;
                m_bp_upd <= 1'b0;
            end else begin
                m_flush  <= acc && mis;
                m_bubble <= !(acc && (i_is_jal || i_is_jalr));
                m_taken  <= acc && tk;
                m_bp_upd <= acc && i_is_b_type && legal;
                m_mean   <= acc;
                m_bpc    <= tgt;
                m_nxt    <= pc4;
                m_bt     <= tk;
                m_idx    <= i_pc[7:0];
            end

            rdl = (i_rd == 5'd1) || (i_rd == 5'd5);
            rsl = (i_rs1 == 5'd1) || (i_rs1 == 5'd5);
            if (acc && i_is_jalr && rdl && rsl && i_rd != i_rs1) begin
                if (m_ras.size() == 0) m_ras.push_back(pc4);
                else m_ras[m_ras.size()-1] = pc4;
            end else if (acc && (i_is_jal || i_is_jalr) && rdl) begin
                m_ras.push_back(pc4);
                if (m_ras.size() > RASD) void'(m_ras.pop_front());
            end else if (acc && i_is_jalr && rsl) begin
                if (m_ras.size() != 0) void'(m_ras.pop_back());
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("flush",   o_flush,        m_flush);
        chk("bubble",  o_bubble,       m_bubble);
        chk("taken",   o_branch_taken, m_taken);
        chk("bp_upd",  o_bp_upd,       m_bp_upd);
        chk("cnt",     o_mispred_cnt,  m_cnt);
        chk("ras_vld", o_ras_valid,    m_ras.size() != 0);
        if (m_ras.size() != 0) chk("ras_top", o_ras_top, m_ras[m_ras.size()-1]);
        if (m_mean) begin
            chk("br_pc",  o_branch_pc,     m_bpc);
            chk("nxt_pc", o_nxt_instr_pc,  m_nxt);
            chk("bp_idx", o_bp_idx_pc,     m_idx);
            chk("bp_bt",  o_bp_sts_btaken, m_bt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        i_bubble = 1'b1; i_is_jal = 1'b0; i_is_jalr = 1'b0; i_is_b_type = 1'b0;
        i_pc = '0; i_rd = '0; i_rs1 = '0; i_funct3 = '0; i_immI = '0; i_immB = '0;
        i_op0 = '0; i_op1 = '0; i_op0_lt_op1 = 1'b0; i_sign_op0_lt_op1 = 1'b0;
        i_pred_taken = 1'b0; i_pred_pc = '0;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [11:0] imm, input logic pt,
                      input logic [31:0] ppc);
        idle();
        i_bubble = 1'b0; i_is_b_type = 1'b1; i_pc = pc; i_funct3 = f3;
        i_op0 = a; i_op1 = b; i_immB = imm; i_pred_taken = pt; i_pred_pc = ppc;
        i_op0_lt_op1 = (a < b);
        i_sign_op0_lt_op1 = ($signed(a) < $signed(b));
    endtask

    task automatic jal(input logic [31:0] pc, input logic [4:0] rd, input logic pt,
                       input logic [31:0] ppc);
        idle();
        i_bubble = 1'b0; i_is_jal = 1'b1; i_pc = pc; i_rd = rd;
        i_pred_taken = pt; i_pred_pc = ppc;
    endtask

    task automatic jalr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [31:0] a, input logic [11:0] imm, input logic pt,
                        input logic [31:0] ppc);
        idle();
        i_bubble = 1'b0; i_is_jalr = 1'b1; i_pc = pc; i_rd = rd; i_rs1 = rs1;
        i_op0 = a; i_immI = imm; i_pred_taken = pt; i_pred_pc = ppc;
    endtask

    initial begin
        int pulses;
        idle();
        aresetn = 1'b0; i_stall = 1'b0; i_cnt_clr = 1'b0;
        cyc(); cyc();
        chk("rst_nxt_pc", o_nxt_instr_pc, PCI);
        chk("rst_br_pc",  o_branch_pc,    PCI);
        chk("rst_bubble", o_bubble,       1);
        chk("rst_idx",    o_bp_idx_pc,    0);
        chk("rst_bt",     o_bp_sts_btaken, 0);
        chk("rst_top",    o_ras_top,      0);
        chk("rst_cnt",    o_mispred_cnt,  0);
        aresetn = 1'b1;
        cyc();

        // BEQ predicted correctly, then with wrong direction
        br(32'h100, 3'd0, 5, 5, 12'h008, 1'b1, 32'h110); cyc();
        chk("beq_taken", o_branch_taken, 1);
        chk("beq_pc",    o_branch_pc,    32'h110);
        chk("beq_flush", o_flush,        0);
        chk("beq_upd",   o_bp_upd,       1);
        br(32'h100, 3'd0, 5, 5, 12'h008, 1'b0, 32'h110); cyc();
        chk("beqw_flush", o_flush, 1);
        idle(); cyc();
        chk("beqw_flush_end", o_flush, 0);
        chk("beqw_cnt", o_mispred_cnt, 1);

        // call then return with a wrong target
        jal(32'h200, 5'd1, 1'b1, 32'h400); cyc();
        chk("call_top", o_ras_top, 32'h204);
        chk("call_vld", o_ras_valid, 1);
        chk("call_bub", o_bubble, 0);
        jalr(32'h400, 5'd0, 5'd1, 32'h204, 12'h000, 1'b1, 32'h208); cyc();
        chk("ret_pc",    o_branch_pc, 32'h204);
        chk("ret_flush", o_flush, 1);
        chk("ret_vld",   o_ras_valid, 0);
        idle(); cyc();

        // RAS overflow then underflow
        for (int k = 0; k < 5; k++) begin
            jal(32'h0C + 32'(k) * 32'h10, 5'd5, 1'b1, 32'h300); cyc();
        end
        chk("ovf_top", o_ras_top, 32'h50);
        jalr(32'h300, 5'd0, 5'd1, 32'h305, 12'hFFD, 1'b1, 32'h302); cyc();
        chk("pop1_top", o_ras_top, 32'h40);
        chk("pop1_pc",  o_branch_pc, 32'h302);
        jalr(32'h300, 5'd0, 5'd5, 32'h300, 12'h000, 1'b1, 32'h300); cyc();
        chk("pop2_top", o_ras_top, 32'h30);
        jalr(32'h300, 5'd0, 5'd5, 32'h300, 12'h000, 1'b1, 32'h300); cyc();
        chk("pop3_top", o_ras_top, 32'h20);
        jalr(32'h300, 5'd0, 5'd5, 32'h300, 12'h000, 1'b1, 32'h300); cyc();
        chk("pop4_vld", o_ras_valid, 0);
        jalr(32'h300, 5'd0, 5'd5, 32'h300, 12'h000, 1'b1, 32'h300); cyc();
        chk("pop5_vld", o_ras_valid, 0);

        // pop+push on empty, then rd==rs1 link push
        jalr(32'h600, 5'd1, 5'd5, 32'h700, 12'h000, 1'b1, 32'h700); cyc();
        chk("pp_top", o_ras_top, 32'h604);
        chk("pp_vld", o_ras_valid, 1);
        jalr(32'h610, 5'd5, 5'd5, 32'h700, 12'h000, 1'b1, 32'h700); cyc();
        chk("same_top", o_ras_top, 32'h614);

        // mispredicted BNE, JAL in the flush cycle is squashed
        br(32'h800, 3'd1, 1, 2, 12'h010, 1'b0, 32'h820); cyc();
        chk("bne_flush", o_flush, 1);
        chk("bne_pc",    o_branch_pc, 32'h820);
        jal(32'h900, 5'd1, 1'b1, 32'hA00); cyc();
        chk("sq_bub", o_bubble, 1);
        chk("sq_top", o_ras_top, 32'h614);
        idle(); cyc();
        chk("sq_cnt", o_mispred_cnt, 3);

        // BLT with negative offset, then BGEU target mismatch followed by stall
        br(32'hA00, 3'd4, 32'hFFFF_FFFF, 1, 12'hFFE, 1'b1, 32'h9FC); cyc();
        chk("blt_pc",    o_branch_pc, 32'h9FC);
        chk("blt_flush", o_flush, 0);
        br(32'hA00, 3'd7, 32'hFFFF_FFFF, 1, 12'h004, 1'b1, 32'hA0C); cyc();
        chk("bgeu_flush", o_flush, 1);
        idle(); i_stall = 1'b1; cyc();
        chk("stall_flush", o_flush, 0);
        cyc();
        chk("sat_cnt", o_mispred_cnt, 3);
        i_stall = 1'b0; cyc();

        // illegal funct3
        br(32'hA40, 3'd2, 1, 1, 12'h004, 1'b0, 32'h0); cyc();
        chk("ill_flush", o_flush, 0);
        chk("ill_upd",   o_bp_upd, 0);

        // predictor strobe under stall
        pulses = 0;
        br(32'hB00, 3'd5, 3, 3, 12'h010, 1'b1, 32'hB20);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin cyc(); pulses += int'(o_bp_upd); end
        i_stall = 1'b0; cyc(); pulses += int'(o_bp_upd);
        chk("bge_pc", o_branch_pc, 32'hB20);
        i_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin cyc(); pulses += int'(o_bp_upd); end
        chk("upd_pulses", pulses, 1);
        chk("hold_pc", o_branch_pc, 32'hB20);
        i_stall = 1'b0; idle(); cyc();

        // counter clear concurrent with a flush
        br(32'hC00, 3'd6, 1, 2, 12'h008, 1'b0, 32'h0); cyc();
        chk("bltu_flush", o_flush, 1);
        i_cnt_clr = 1'b1; idle(); cyc();
        chk("clr_cnt", o_mispred_cnt, 0);
        i_cnt_clr = 1'b0;

        // reset while a flush is pending
        br(32'hD00, 3'd0, 1, 2, 12'h008, 1'b1, 32'hD10); cyc();
        chk("rm_flush", o_flush, 1);
        idle(); aresetn = 1'b0; cyc();
        chk("rm_flush_drop", o_flush, 0);
        chk("rm_vld", o_ras_valid, 0);
        aresetn = 1'b1; cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exu_branch_resolve_unit.md
# exu_branch_resolve_unit

Parametrised branch resolution unit for the PQR5 Execution Unit (EXU), the next generation of the EXU branch unit. It resolves JAL, JALR and B-type instructions and checks both direction and target against the fetch-stage prediction, so a wrong target also triggers a flush, not only a wrong direction. It also maintains a return address stack (RAS) of configurable depth that feeds return-target predictions to the Fetch Unit, and a saturating misprediction counter.

## Interface
- `XLEN`, 32, datapath/PC width
- `PC_INIT`, 0, PC value loaded into PC-type registers on reset
- `RAS_DEPTH`, 4, RAS entries; power of 2, ≥2
- `BPCW`, 8, PC LSBs forwarded to the predictor for BHT indexing
- `CNTW`, 16, misprediction counter width
- Clock/reset decision: one clock `clk`; reset `aresetn` is synchronous and active-low.
- `clk` in 1 clock
- `aresetn` in 1 synchronous active-low reset
- `i_stall` in 1 pipeline stall; freezes all state except the flush-enable clear
- `i_bubble` in 1 input slot holds no valid instruction
- `i_pc` in XLEN PC of the instruction
- `i_is_jal`, `i_is_jalr`, `i_is_b_type` in 1 each; one-hot or all zero
- `i_rd`, `i_rs1` in 5 each; register indices
- `i_funct3` in 3 branch condition
- `i_immI`, `i_immB` in 12 each; raw immediates
- `i_op0`, `i_op1` in XLEN register operands
- `i_op0_lt_op1`, `i_sign_op0_lt_op1` in 1 each; comparison flags from the ALU
- `i_pred_taken` in 1 direction predicted by the Fetch Unit (FU)
- `i_pred_pc` in XLEN target predicted by the FU
- `i_cnt_clr` in 1 clears the misprediction counter
- `o_nxt_instr_pc` out XLEN registered PC+4 (link value)
- `o_bubble` out 1 registered bubble
- `o_branch_taken` out 1 registered resolved direction
- `o_branch_pc` out XLEN registered resolved next PC
- `o_flush` out 1 misprediction flush pulse
- `o_ras_top`, `o_ras_valid` out XLEN, 1; current RAS top entry and non-empty flag
- `o_bp_upd`, `o_bp_idx_pc`, `o_bp_sts_btaken` out 1, BPCW, 1; predictor update strobe, index and resolved direction
- `o_mispred_cnt` out CNTW saturating flush count

## Operation
- **Accept condition.**
  - An instruction is accepted when `!i_stall && !i_bubble && !squash`.
  - `squash = o_flush`: the instruction presented while flush is high is on the wrong path and is treated as a bubble.
- **Direction.**
  - JAL and JALR are always taken.
  - B-type uses `i_funct3`: BEQ `op0==op1`; BNE `!=`; BLT signed `<`; BGE signed `>=`; BLTU unsigned `<`; BGEU unsigned `>=`.
  - funct3 010 and 011 are illegal: not taken, and they generate no predictor update.
  - Any other instruction is not taken.
- **Target arithmetic.** All sums are modulo 2^XLEN.
  - JAL: `i_pred_pc` is trusted and no target is computed; the branch PC is `i_pred_pc`.
  - JALR: `(op0 + sext(immI)) & ~1`.
  - B-type taken: `pc + (sext(immB) << 1)`.
  - Not taken: `pc + 4`.
- **Mispredict.** `dir_mis = taken != i_pred_taken`; `tgt_mis = taken && (branch_pc != i_pred_pc)`. Both are registered together with an enable `en_cmp <= accepted`. `o_flush = en_cmp_rg & (dir_mis_rg | tgt_mis_rg)`.
- **Flush enable clear.** When `o_flush` is high, `en_cmp_rg` clears on the next edge even if `i_stall` is high, so flush is always a single-cycle pulse.
- **Bubble.** `o_bubble <= !(accepted && (jal || jalr))`, so only jumps propagate for writeback.
- **RAS.** Link registers are x1 and x5; rd_link and rs1_link mean `rd` or `rs1` is one of them. Actions apply on accept only:
  - push: (jal or jalr) & rd_link & !(jalr & rs1_link & rd≠rs1).
  - pop: jalr & rs1_link & !rd_link.
  - pop+push: jalr & rd_link & rs1_link & rd≠rs1.
  - push with rd==rs1 link: push only.
- **RAS storage.**
  - Circular buffer with pointer `tp` and counter `cnt` (0..RAS_DEPTH).
  - Push: `tp+1` (wraps), writes `pc+4`, `cnt=min(cnt+1,RAS_DEPTH)`. Overflow silently overwrites the oldest entry.
  - Pop: if `cnt>0`, `tp-1` (wraps) and `cnt-1`. Pop on empty leaves `tp` and `cnt` unchanged.
  - Pop+push: overwrites entry at `tp` with `pc+4`; `cnt` unchanged, except `cnt` goes 0→1.
  - `o_ras_top = ras[tp]`; `o_ras_valid = cnt!=0`.
- **Predictor update.** `o_bp_upd <= accepted & legal B-type`, but the strobe is driven 0 during `i_stall` so there is never a double update. `o_bp_idx_pc <= pc[BPCW-1:0]`.
- **Counter.** `o_mispred_cnt` increments on each `o_flush` and saturates at all-ones. `i_cnt_clr` has priority and clears it to 0 on the same edge, even if a flush occurs.

## Timing
- **Latency.** All result outputs are registered with 1-cycle latency from accept. `o_flush` is combinational from registers only (no input-to-output path).
- **Stall.** All pipeline registers, the RAS and the counter hold. The exception is `en_cmp_rg`, which clears after a flush.
- **RAS visibility.** RAS updates are visible on `o_ras_top` the cycle after accept.
- **Reset values.**
  - PC registers: `o_nxt_instr_pc=o_branch_pc=PC_INIT`.
  - `o_bubble=1`, `o_branch_taken=0`, `o_flush=0`, `o_bp_upd=0`, `o_bp_idx_pc=0`, `o_bp_sts_btaken=0`.
  - `tp=0`, `cnt=0`, `o_ras_valid=0`, `o_ras_top=0` (storage cleared), `o_mispred_cnt=0`.
- **Reset mid-operation.** Reset asserted while a flush is pending drops the flush at the next edge.

## Test plan
- **BEQ correct, BEQ wrong direction.** BEQ, pc=0x100, op0=op1=5, immB=0x008, pred_taken=1, pred_pc=0x110 → next cycle taken=1, branch_pc=0x110, flush=0. Repeat with pred_taken=0 → flush=1 for exactly one cycle, counter=1.
- **Call then return.** JAL rd=x1 at 0x200 → ras_top=0x204, valid=1. Then JALR rd=x0 rs1=x1, op0=0x204, pred_pc=0x208 → branch_pc=0x204, flush=1 (target mismatch), RAS empty.
- **RAS overflow and underflow.** With RAS_DEPTH=4, 5 pushes of 0x10,0x20,0x30,0x40,0x50 → top=0x50. 4 pops expose 0x40,0x30,0x20, then empty. A 5th pop keeps valid=0.
- **Flush and stall interaction.**
  - A mispredicted BNE followed by a JAL in the flush cycle → JAL is squashed: o_bubble=1, no RAS push.
  - Flush concurrent with `i_stall`=1 → flush still lasts one cycle.
- **Illegal funct3 and stall update gating.**
  - funct3=010 with pred_taken=0 → no flush, o_bp_upd=0.
  - A legal branch held under `i_stall` for 3 cycles → o_bp_upd pulses once.
- **Counter saturation and clear.** With CNTW=2, 4 flushes → counter=3. `i_cnt_clr` concurrent with a flush → counter=0.
